mem_arbiter: RTL and testbench

- Shares the single external memory port (mem_read/mem_write/mem_addr/mem_wdata/mem_rdata) between I-cache line refills and D-cache line refills/writebacks.
- Sits between ir_cache/data_cache and the processor's top-level memory pins.
- Performs fixed-length bursts of LINE_WORDS words with per-beat wait-state handshake (mem_ready), round-robin arbitration, one release cycle between grants.

---
 rtl/mem_arbiter.sv | 92 +++++++++
 tb/tb_mem_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin burst arbiter sharing one memory port between I-cache refills and D-cache refills/writebacks
module mem_arbiter #(
    parameter int WORD_WIDTH = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [WORD_WIDTH-1:0] i_addr,
    output logic [WORD_WIDTH-1:0] i_rdata,
    output logic                  i_rvalid,
    output logic                  i_done,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [WORD_WIDTH-1:0] d_addr,
    input  logic [WORD_WIDTH-1:0] d_wdata,
    output logic                  d_wnext,
    output logic [WORD_WIDTH-1:0] d_rdata,
    output logic                  d_rvalid,
    output logic                  d_done,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [WORD_WIDTH-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0] mem_wdata,
    input  logic [WORD_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic                  busy
);
    localparam int BW = LINE_WORDS > 1 ? $clog2(LINE_WORDS) : 1;

    typedef enum logic [2:0] {IDLE, XFER_I, XFER_DRD, XFER_DWR, RELEASE} state_t;

    state_t                state_q, state_d;
    logic [BW-1:0]         beat_q, beat_d;
    logic [WORD_WIDTH-1:0] base_q, base_d;
    logic                  last_d_q, last_d_d;
    logic                  xfer, last_beat, pick_d;

    assign xfer      = state_q inside {XFER_I, XFER_DRD, XFER_DWR};
    assign last_beat = beat_q == BW'(LINE_WORDS - 1);
    // D wins unless I is also asking and D had the previous grant
    assign pick_d    = d_req & (~i_req | ~last_d_q);

    assign busy      = state_q != IDLE;
    assign mem_read  = (state_q == XFER_I) | (state_q == XFER_DRD);
    assign mem_write = state_q == XFER_DWR;
    assign mem_addr  = xfer ? base_q + WORD_WIDTH'({beat_q, 2'b00}) : '0;
    assign mem_wdata = mem_write ? d_wdata : '0;
    assign i_rdata   = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign i_rvalid  = mem_ready & (state_q == XFER_I);
    assign d_rvalid  = mem_ready & (state_q == XFER_DRD);
    assign d_wnext   = mem_ready & mem_write;
    assign i_done    = i_rvalid & last_beat;
    assign d_done    = (d_rvalid | d_wnext) & last_beat;

    // Grant, beat advance and release sequencing
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        base_d   = base_q;
        last_d_d = last_d_q;
        case (state_q)
            IDLE: if (i_req | d_req) begin
                base_d   = (pick_d ? d_addr : i_addr) & ~WORD_WIDTH'(3);
                beat_d   = '0;
                last_d_d = pick_d;
                state_d  = pick_d ? (d_we ? XFER_DWR : XFER_DRD) : XFER_I;
            end
            RELEASE: state_d = IDLE;
            default: if (mem_ready) begin
                beat_d  = beat_q + BW'(1);
                state_d = last_beat ? RELEASE : state_q;
            end
        endcase
    end

    // State registers; reset leaves I as last grant so D wins the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            base_q   <= '0;
            last_d_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            base_q   <= base_d;
            last_d_q <= last_d_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors, corner sequences and a randomized burst-level model for mem_arbiter
module tb_mem_arbiter;
    localparam int LW = 4;

    logic        clk = 1'b0;
    logic        rst, i_req, d_req, d_we, mem_ready;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic        i_rvalid, i_done, d_wnext, d_rvalid, d_done, mem_read, mem_write, busy;

    int checks = 0;
    int failures = 0;

    mem_arbiter #(.WORD_WIDTH(32), .LINE_WORDS(LW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wnext(d_wnext),
        .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_done(d_done),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Burst-level reference: the current burst is a queue of beat addresses still to transfer
    int          m_owner = -1;
    bit          m_rel = 1'b0;
    bit          m_last_d = 1'b0;
    bit          armed = 1'b0;
    bit          i_fin = 1'b0;
    bit          d_fin = 1'b0;
    bit          pd, m_last;
    logic [31:0] m_q[$];
    logic [31:0] b, ea;

    always @(negedge clk) begin
        ea = (m_owner >= 0) ? m_q[0] : 32'h0;
        m_last = m_owner >= 0 && mem_ready && m_q.size() == 1;
        i_fin = m_last && m_owner == 0;
        d_fin = m_last && m_owner > 0;
        if (armed) begin
            chk1("mdl.busy", busy, m_owner >= 0 || m_rel);
            chk1("mdl.mem_read", mem_read, m_owner == 0 || m_owner == 1);
            chk1("mdl.mem_write", mem_write, m_owner == 2);
            chk("mdl.mem_addr", mem_addr, ea);
            chk("mdl.mem_wdata", mem_wdata, m_owner == 2 ? d_wdata : 32'h0);
            chk1("mdl.i_rvalid", i_rvalid, mem_ready && m_owner == 0);
            chk1("mdl.d_rvalid", d_rvalid, mem_ready && m_owner == 1);
            chk1("mdl.d_wnext", d_wnext, mem_ready && m_owner == 2);
            chk1("mdl.i_done", i_done, i_fin);
            chk1("mdl.d_done", d_done, d_fin);
            chk("mdl.i_rdata", i_rdata, mem_rdata);
            chk("mdl.d_rdata", d_rdata, mem_rdata);
        end
        if (rst) begin
            m_owner = -1;
            m_rel = 1'b0;
            m_last_d = 1'b0;
            m_q.delete();
        end else if (m_rel) begin
            m_rel = 1'b0;
        end else if (m_owner >= 0) begin
            if (mem_ready) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) begin
                    m_owner = -1;
                    m_rel = 1'b1;
                end
            end
        end else if (i_req || d_req) begin
            pd = d_req && (!i_req || !m_last_d);
            b = (pd ? d_addr : i_addr) & ~32'h3;
            m_owner = pd ? (d_we ? 2 : 1) : 0;
            m_last_d = pd;
            for (int k = 0; k < LW; k++) m_q.push_back(b + 32'(4 * k));
        end
    end

    // flags = {mem_read, mem_write, i_rvalid, i_done, d_rvalid, d_done, d_wnext, busy}
    typedef struct {
        logic [2:0]  ctl;
        logic [31:0] ia, da, wd, rdat;
        logic [7:0]  ef;
        logic [31:0] ea, ewd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [2:0] ctl, input logic [31:0] ia, input logic [31:0] da,
                                input logic [31:0] wd, input logic [31:0] rdat, input logic [7:0] ef,
                                input logic [31:0] ea, input logic [31:0] ewd);
        vec_t v;
        v.ctl = ctl; v.ia = ia; v.da = da; v.wd = wd; v.rdat = rdat; v.ef = ef; v.ea = ea; v.ewd = ewd;
        return v;
    endfunction

    int   starts[$];
    bit   owners_d[$];
    bit   exp_o[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    bit   prev;
    int   dones, nrv;

    initial begin
        // ctl = {i_req, d_req, d_we}
        tbl.push_back(mk(3'b100, 32'h103, 32'h0, 32'h0, 32'h0,  8'b00000000, 32'h0,   32'h0));
        tbl.push_back(mk(3'b100, 32'h103, 32'h0, 32'h0, 32'hA0, 8'b10100001, 32'h100, 32'h0));
        tbl.push_back(mk(3'b100, 32'h777, 32'h0, 32'h0, 32'hA1, 8'b10100001, 32'h104, 32'h0));
        tbl.push_back(mk(3'b100, 32'h777, 32'h0, 32'h0, 32'hA2, 8'b10100001, 32'h108, 32'h0));
        tbl.push_back(mk(3'b100, 32'h777, 32'h0, 32'h0, 32'hA3, 8'b10110001, 32'h10C, 32'h0));
        tbl.push_back(mk(3'b000, 32'h0,   32'h0, 32'h0, 32'h0,  8'b00000001, 32'h0,   32'h0));
        tbl.push_back(mk(3'b000, 32'h0,   32'h0, 32'h0, 32'h0,  8'b00000000, 32'h0,   32'h0));
        tbl.push_back(mk(3'b011, 32'h0, 32'h200, 32'h11, 32'h0, 8'b00000000, 32'h0,   32'h0));
        tbl.push_back(mk(3'b011, 32'h0, 32'h200, 32'h11, 32'h0, 8'b01000011, 32'h200, 32'h11));
        tbl.push_back(mk(3'b010, 32'h0, 32'h9F0, 32'h12, 32'h0, 8'b01000011, 32'h204, 32'h12));
        tbl.push_back(mk(3'b010, 32'h0, 32'h9F0, 32'h13, 32'h0, 8'b01000011, 32'h208, 32'h13));
        tbl.push_back(mk(3'b011, 32'h0, 32'h9F0, 32'h14, 32'h0, 8'b01000111, 32'h20C, 32'h14));
        tbl.push_back(mk(3'b000, 32'h0, 32'h0,   32'h14, 32'h0, 8'b00000001, 32'h0,   32'h0));
        tbl.push_back(mk(3'b000, 32'h0, 32'h0,   32'h0,  32'h0, 8'b00000000, 32'h0,   32'h0));

        rst = 1'b1; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; mem_ready = 1'b1;
        i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; mem_rdata = 32'h0;
        @(posedge clk); #1;
        armed = 1'b1;
        @(negedge clk);
        chk1("rst.busy", busy, 1'b0);
        chk1("rst.mem_read", mem_read, 1'b0);
        chk1("rst.mem_write", mem_write, 1'b0);
        chk("rst.mem_addr", mem_addr, 32'h0);
        chk1("rst.done", i_done | d_done, 1'b0);
        chk1("rst.valid", i_rvalid | d_rvalid | d_wnext, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Contention with both requests held: expect D, I, D, I at LW+2 cycle spacing
        prev = 1'b0; dones = 0;
        for (int k = 0; k < 60 && dones < 4; k++) begin
            @(negedge clk);
            chk1("cont.exclusive", mem_read & mem_write, 1'b0);
            if ((mem_read | mem_write) && !prev) begin
                starts.push_back(k);
                owners_d.push_back(d_rvalid);
            end
            prev = mem_read | mem_write;
            dones += int'(i_done) + int'(d_done);
            @(posedge clk); #1;
            if (dones == 4) begin
                i_req = 1'b0;
                d_req = 1'b0;
            end
        end
        chk("cont.dones", dones, 4);
        chk("cont.bursts", starts.size(), 4);
        if (starts.size() == 4) begin
            chk("cont.first_start", starts[0], 1);
            for (int j = 0; j < 4; j++) chk1($sformatf("cont.owner%0d_is_d", j), owners_d[j], exp_o[j]);
            for (int j = 0; j < 3; j++) chk($sformatf("cont.spacing%0d", j), starts[j + 1] - starts[j], LW + 2);
        end
        @(posedge clk); #1;

        // Directed I refill and D writeback vectors
        foreach (tbl[n]) begin
            {i_req, d_req, d_we} = tbl[n].ctl;
            i_addr = tbl[n].ia; d_addr = tbl[n].da; d_wdata = tbl[n].wd; mem_rdata = tbl[n].rdat;
            mem_ready = 1'b1;
            @(negedge clk);
            chk($sformatf("vec%0d.flags", n),
                32'({mem_read, mem_write, i_rvalid, i_done, d_rvalid, d_done, d_wnext, busy}), 32'(tbl[n].ef));
            chk($sformatf("vec%0d.mem_addr", n), mem_addr, tbl[n].ea);
            chk($sformatf("vec%0d.mem_wdata", n), mem_wdata, tbl[n].ewd);
            chk($sformatf("vec%0d.i_rdata", n), i_rdata, tbl[n].rdat);
            @(posedge clk); #1;
        end

        // Wait states: D read at 0x300 with mem_ready every third transfer cycle
        nrv = 0;
        for (int c = 0; c < 15; c++) begin
            d_req = c <= 12; d_we = 1'b0; d_addr = 32'h300; i_req = 1'b0; mem_rdata = $urandom;
            mem_ready = c == 0 || c >= 13 || (c >= 1 && (c - 1) % 3 == 2);
            @(negedge clk);
            chk($sformatf("ws.addr%0d", c), mem_addr, (c >= 1 && c <= 12) ? 32'h300 + 32'(4 * ((c - 1) / 3)) : 32'h0);
            chk1($sformatf("ws.done%0d", c), d_done, c == 12);
            chk1($sformatf("ws.busy%0d", c), busy, c >= 1 && c <= 13);
            nrv += int'(d_rvalid);
            @(posedge clk); #1;
        end
        chk("ws.rvalid_pulses", nrv, 4);

        // Reset in the middle of an I refill, then a fresh refill from 0x400
        for (int c = 0; c < 11; c++) begin
            i_req = c <= 8; d_req = 1'b0; mem_ready = 1'b1; mem_rdata = $urandom;
            i_addr = c < 4 ? 32'h500 : 32'h400;
            rst = c == 3;
            @(negedge clk);
            chk1($sformatf("rm.read%0d", c), mem_read, (c >= 1 && c <= 3) || (c >= 5 && c <= 8));
            chk($sformatf("rm.addr%0d", c), mem_addr,
                (c >= 1 && c <= 3) ? 32'h500 + 32'(4 * (c - 1)) : (c >= 5 && c <= 8) ? 32'h400 + 32'(4 * (c - 5)) : 32'h0);
            chk1($sformatf("rm.done%0d", c), i_done, c == 8);
            chk1($sformatf("rm.busy%0d", c), busy, (c >= 1 && c <= 3) || (c >= 5 && c <= 9));
            @(posedge clk); #1;
        end

        // Randomized requesters obeying the hold-until-done protocol
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom % 400) == 0;
            i_req = i_fin ? 1'b0 : (i_req ? ($urandom % 16 != 0) : ($urandom % 3 == 0));
            d_req = d_fin ? 1'b0 : (d_req ? ($urandom % 16 != 0) : ($urandom % 3 == 0));
            i_addr = $urandom; d_addr = $urandom; d_we = 1'($urandom);
            d_wdata = $urandom; mem_rdata = $urandom; mem_ready = ($urandom % 4) != 0;
            @(posedge clk); #1;
        end
        rst = 1'b0; i_req = 1'b0; d_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
